uart_rx: RTL and testbench

UART receive stage: consumes the serial stream that the transmit stage drives onto the line, whether from an external peer or via internal loopback. It recovers characters using 16x oversampling and checks parity, framing and break. It buffers received characters, with per-character error flags, in a 16-entry FIFO that the UART register file drains. It shares the LCR/FCR configuration fields with the transmitter and takes its oversampling tick from the baud generator.

---
 rtl/uart_pkg.sv | 37 +++
 rtl/uart_rx_fifo.sv | 66 ++++++
 rtl/uart_rx.sv | 178 +++++++++++++++++
 tb/tb_uart_rx.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants for the receive path: FSM states, per-character
// error flags, FIFO entry layout and oversampling constants.
package uart_pkg;

   localparam int OS_RATE = 16;
   localparam int OS_MID  = 7;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PAR,
      RX_STOP
   } state_type_rx;

   typedef struct packed {
      logic brk;
      logic frame;
      logic par;
   } rx_err_t;

   typedef struct packed {
      rx_err_t    err;
      logic [7:0] data;
   } rx_entry_t;

   // Expected parity bit; data arrives with unused upper bits already zero.
   function automatic logic par_expect(input logic [7:0] data, input logic [1:0] sel);
      case (sel)
         2'b00:   return ~^data;
         2'b01:   return ^data;
         2'b10:   return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive character FIFO with usage count, runtime depth limit (1 or DEPTH),
// overrun pulse on a dropped push, and a flush that beats a same-cycle push.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH),
   localparam int UW = AW + 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          clr_i,
   input  logic          single_i,
   input  logic          push_i,
   input  rx_entry_t     push_entry_i,
   input  logic          pop_i,
   output rx_entry_t     head_o,
   output logic          valid_o,
   output logic [UW-1:0] usage_o,
   output logic          overrun_o
);

   rx_entry_t       mem [DEPTH];
   logic [AW-1:0]   wr_ptr_reg;
   logic [AW-1:0]   rd_ptr_reg;
   logic [UW-1:0]   count_reg;
   logic            overrun_reg;
   logic [UW-1:0]   limit;
   logic            pop_ok;
   logic            push_ok;

   assign limit   = single_i ? UW'(1) : UW'(DEPTH);
   assign pop_ok  = pop_i && (count_reg != '0);
   // A pop in the same cycle frees the slot before the push lands.
   assign push_ok = push_i && ((count_reg < limit) || pop_ok);

   always_ff @(posedge clk_i) begin
      if (push_ok && !clr_i) begin
         mem[wr_ptr_reg] <= push_entry_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         count_reg   <= '0;
         overrun_reg <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         count_reg   <= count_reg + UW'(push_ok) - UW'(pop_ok);
         overrun_reg <= push_i && !push_ok;
      end
   end

   assign valid_o   = (count_reg != '0);
   assign usage_o   = count_reg;
   assign overrun_o = overrun_reg;
   assign head_o    = valid_o ? mem[rd_ptr_reg] : '0;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled start/data/parity/stop recovery with break and
// framing detection, feeding a character FIFO drained by the register file.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       rxd_i,
   input  logic       os_tick_i,
   input  logic [1:0] word_len_i,
   input  logic       par_en_i,
   input  logic [1:0] par_sel_i,
   input  logic       fifo_en_i,
   input  logic       fifo_clr_i,
   output logic [7:0] rx_data_o,
   output logic [2:0] rx_err_o,
   output logic       rx_valid_o,
   input  logic       rx_pop_i,
   output logic [4:0] rx_usage_o,
   output logic       overrun_o,
   output logic       busy_o
);

   localparam logic [3:0] OS_LAST = 4'(OS_RATE - 1);
   localparam logic [3:0] OS_HALF = 4'(OS_MID);
   localparam int UW = $clog2(DEPTH) + 1;

   logic          sync1_reg;
   logic          rxd_s_reg;
   state_type_rx  state_reg;
   logic [3:0]    os_cnt_reg;
   logic [2:0]    bit_cnt_reg;
   logic [7:0]    shift_reg;
   logic          armed_reg;
   logic [1:0]    wl_reg;
   logic          pen_reg;
   logic [1:0]    psel_reg;
   logic          par_bit_reg;
   logic          par_err_reg;
   logic          fifo_en_reg;
   logic          stop_hit;
   logic          fifo_clr;
   logic          frame_err;
   rx_entry_t     push_entry;
   rx_entry_t     head;
   logic [UW-1:0] usage;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_reg <= 1'b1;
         rxd_s_reg <= 1'b1;
      end else begin
         sync1_reg <= rxd_i;
         rxd_s_reg <= sync1_reg;
      end
   end

   assign stop_hit = (state_reg == RX_STOP) && os_tick_i && (os_cnt_reg == OS_LAST);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg   <= RX_IDLE;
         os_cnt_reg  <= '0;
         bit_cnt_reg <= '0;
         shift_reg   <= '0;
         armed_reg   <= 1'b0;
         wl_reg      <= '0;
         pen_reg     <= 1'b0;
         psel_reg    <= '0;
         par_bit_reg <= 1'b0;
         par_err_reg <= 1'b0;
      end else begin
         // After a break the line must go high again before a new start is accepted.
         if (stop_hit) begin
            armed_reg <= 1'b0;
         end else if (rxd_s_reg) begin
            armed_reg <= 1'b1;
         end
         case (state_reg)
            RX_IDLE: begin
               if (!rxd_s_reg && armed_reg) begin
                  state_reg   <= RX_START;
                  os_cnt_reg  <= '0;
                  bit_cnt_reg <= '0;
                  shift_reg   <= '0;
                  par_bit_reg <= 1'b0;
                  par_err_reg <= 1'b0;
                  wl_reg      <= word_len_i;
                  pen_reg     <= par_en_i;
                  psel_reg    <= par_sel_i;
               end
            end
            RX_START: begin
               if (os_tick_i) begin
                  if (os_cnt_reg == OS_HALF) begin
                     os_cnt_reg <= '0;
                     state_reg  <= rxd_s_reg ? RX_IDLE : RX_DATA;
                  end else begin
                     os_cnt_reg <= os_cnt_reg + 4'd1;
                  end
               end
            end
            RX_DATA: begin
               if (os_tick_i) begin
                  os_cnt_reg <= os_cnt_reg + 4'd1;
                  if (os_cnt_reg == OS_LAST) begin
                     shift_reg[bit_cnt_reg] <= rxd_s_reg;
                     if (bit_cnt_reg == ({1'b0, wl_reg} + 3'd4)) begin
                        bit_cnt_reg <= '0;
                        state_reg   <= pen_reg ? RX_PAR : RX_STOP;
                     end else begin
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                     end
                  end
               end
            end
            RX_PAR: begin
               if (os_tick_i) begin
                  os_cnt_reg <= os_cnt_reg + 4'd1;
                  if (os_cnt_reg == OS_LAST) begin
                     par_bit_reg <= rxd_s_reg;
                     par_err_reg <= rxd_s_reg != par_expect(shift_reg, psel_reg);
                     state_reg   <= RX_STOP;
                  end
               end
            end
            RX_STOP: begin
               if (os_tick_i) begin
                  os_cnt_reg <= os_cnt_reg + 4'd1;
                  if (os_cnt_reg == OS_LAST) begin
                     state_reg <= RX_IDLE;
                  end
               end
            end
            default: state_reg <= RX_IDLE;
         endcase
      end
   end

   always_comb begin
      frame_err            = ~rxd_s_reg;
      push_entry.data      = shift_reg;
      push_entry.err.par   = par_err_reg;
      push_entry.err.frame = frame_err;
      push_entry.err.brk   = frame_err && (shift_reg == 8'd0) && (!pen_reg || !par_bit_reg);
   end

   // Any change of fifo_en_i is treated as a one-cycle flush.
   always_ff @(posedge clk_i) begin
      fifo_en_reg <= fifo_en_i;
   end

   assign fifo_clr = fifo_clr_i || (fifo_en_i != fifo_en_reg);

   uart_rx_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clr_i       (fifo_clr),
      .single_i    (!fifo_en_i),
      .push_i      (stop_hit),
      .push_entry_i(push_entry),
      .pop_i       (rx_pop_i),
      .head_o      (head),
      .valid_o     (rx_valid_o),
      .usage_o     (usage),
      .overrun_o   (overrun_o)
   );

   assign rx_data_o  = head.data;
   assign rx_err_o   = head.err;
   assign rx_usage_o = 5'(usage);
   assign busy_o     = (state_reg != RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are serialised from a behavioural model,
// expected entries are queued at issue time and a monitor pops and compares them.
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int DEPTH = 16;

   typedef struct packed {
      logic [2:0] err;
      logic [7:0] data;
   } exp_t;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       rxd_i;
   logic       os_tick_i;
   logic [1:0] word_len_i;
   logic       par_en_i;
   logic [1:0] par_sel_i;
   logic       fifo_en_i;
   logic       fifo_clr_i;
   logic [7:0] rx_data_o;
   logic [2:0] rx_err_o;
   logic       rx_valid_o;
   logic       rx_pop_i;
   logic [4:0] rx_usage_o;
   logic       overrun_o;
   logic       busy_o;

   exp_t exp_q[$];
   int   n_checks  = 0;
   int   n_fail    = 0;
   int   mcount    = 0;
   int   exp_ovr   = 0;
   int   ovr_seen  = 0;
   bit   drain_en  = 1'b0;
   int   base_seen;
   int   base_exp;
   bit   prev_busy;
   bit   prev_valid;
   bit   push_seen;

   uart_rx #(.DEPTH(DEPTH)) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .rxd_i     (rxd_i),
      .os_tick_i (os_tick_i),
      .word_len_i(word_len_i),
      .par_en_i  (par_en_i),
      .par_sel_i (par_sel_i),
      .fifo_en_i (fifo_en_i),
      .fifo_clr_i(fifo_clr_i),
      .rx_data_o (rx_data_o),
      .rx_err_o  (rx_err_o),
      .rx_valid_o(rx_valid_o),
      .rx_pop_i  (rx_pop_i),
      .rx_usage_o(rx_usage_o),
      .overrun_o (overrun_o),
      .busy_o    (busy_o)
   );

   always #5 clk_i = ~clk_i;

   // Oversampling tick: one cycle high every four clocks.
   initial begin
      os_tick_i = 1'b0;
      forever begin
         repeat (3) @(posedge clk_i);
         #1 os_tick_i = 1'b1;
         @(posedge clk_i);
         #1 os_tick_i = 1'b0;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_ticks(input int n);
      repeat (n) begin
         @(posedge clk_i);
         while (!os_tick_i) @(posedge clk_i);
      end
      #1;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   function automatic void model_flush();
      exp_q.delete();
      mcount = 0;
   endfunction

   function automatic void model_push(input exp_t e);
      int limit;
      limit = fifo_en_i ? DEPTH : 1;
      if (mcount < limit) begin
         exp_q.push_back(e);
         mcount++;
      end else begin
         exp_ovr++;
      end
   endfunction

   // Character as the line would deliver it, judged only from the frame rules.
   function automatic exp_t model_frame(input logic [7:0] d, input logic [1:0] wl, input logic pen,
                                        input logic [1:0] psel, input logic pbit, input logic stopb);
      exp_t e;
      int   nbits;
      int   ones;
      logic want;
      logic [7:0] md;
      nbits = int'(wl) + 5;
      md    = d & 8'((1 << nbits) - 1);
      ones  = $countones(md);
      case (psel)
         2'b00:   want = (ones % 2 == 0);
         2'b01:   want = (ones % 2 == 1);
         2'b10:   want = 1'b1;
         default: want = 1'b0;
      endcase
      e.data   = md;
      e.err[0] = pen && (pbit != want);
      e.err[1] = !stopb;
      e.err[2] = !stopb && (md == 8'd0) && (!pen || !pbit);
      return e;
   endfunction

   task automatic do_frame(input logic [7:0] d, input logic [1:0] wl, input logic pen,
                           input logic [1:0] psel, input logic pbit, input logic stopb,
                           input bit clr_stop);
      int nbits;
      nbits = int'(wl) + 5;
      if (!clr_stop) model_push(model_frame(d, wl, pen, psel, pbit, stopb));
      word_len_i = wl;
      par_en_i   = pen;
      par_sel_i  = psel;
      rxd_i = 1'b0;
      wait_ticks(16);
      for (int i = 0; i < nbits; i++) begin
         rxd_i = d[i];
         if (i == 0) begin
            // The frame format is latched at the start edge; later changes must not matter.
            word_len_i = 2'($urandom_range(0, 3));
            par_en_i   = 1'($urandom_range(0, 1));
            par_sel_i  = 2'($urandom_range(0, 3));
         end
         wait_ticks(16);
      end
      if (pen) begin
         rxd_i = pbit;
         wait_ticks(16);
      end
      rxd_i = stopb;
      if (clr_stop) begin
         wait_ticks(4);
         fifo_clr_i = 1'b1;
         wait_ticks(8);
         fifo_clr_i = 1'b0;
         wait_ticks(4);
      end else begin
         wait_ticks(16);
      end
      rxd_i = 1'b1;
      wait_ticks(1 + $urandom_range(0, 2));
   endtask

   task automatic drain();
      drain_en = 1'b1;
      for (int k = 0; k < 400 && (exp_q.size() != 0 || rx_valid_o); k++) @(negedge clk_i);
      check("drain_queue_empty", exp_q.size(), 0);
      check("drain_valid_low", rx_valid_o, 1'b0);
      drain_en = 1'b0;
      wait_cycles(2);
   endtask

   // Monitor: pops every presented entry while draining and scores it.
   initial begin
      exp_t e;
      rx_pop_i = 1'b0;
      forever begin
         @(negedge clk_i);
         if (drain_en && rx_valid_o && !rst_i) begin
            if (exp_q.size() == 0) begin
               check("unexpected_entry", {rx_err_o, rx_data_o}, 0);
            end else begin
               e = exp_q.pop_front();
               mcount--;
               $display("rx entry: data=0x%02h err=%03b (expected 0x%02h %03b)",
                        rx_data_o, rx_err_o, e.data, e.err);
               check("entry_data", rx_data_o, e.data);
               check("entry_err", rx_err_o, e.err);
            end
            rx_pop_i = 1'b1;
            @(negedge clk_i);
            rx_pop_i = 1'b0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk_i);
         if (overrun_o) ovr_seen++;
      end
   end

   initial begin
      rst_i      = 1'b1;
      rxd_i      = 1'b1;
      word_len_i = 2'b11;
      par_en_i   = 1'b0;
      par_sel_i  = 2'b00;
      fifo_en_i  = 1'b1;
      fifo_clr_i = 1'b0;
      wait_cycles(3);
      check("rst_data", rx_data_o, 0);
      check("rst_err", rx_err_o, 0);
      check("rst_valid", rx_valid_o, 0);
      check("rst_usage", rx_usage_o, 0);
      check("rst_overrun", overrun_o, 0);
      check("rst_busy", busy_o, 0);
      rst_i = 1'b0;
      wait_cycles(4);

      // 8N1 0xA5, valid must rise on the edge that ends the stop-sample cycle.
      prev_busy  = 1'b0;
      prev_valid = 1'b0;
      push_seen  = 1'b0;
      fork
         do_frame(8'hA5, 2'b11, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
         begin
            for (int k = 0; k < 2000 && !push_seen; k++) begin
               @(negedge clk_i);
               if (prev_busy && !busy_o) begin
                  push_seen = 1'b1;
                  check("a5_valid_before_push", prev_valid, 1'b0);
                  check("a5_valid_after_push", rx_valid_o, 1'b1);
                  check("a5_usage_after_push", rx_usage_o, 1);
               end
               prev_busy  = busy_o;
               prev_valid = rx_valid_o;
            end
            check("a5_push_seen", push_seen, 1'b1);
         end
      join
      drain();

      // 5E1 0x15: good parity then bad parity.
      do_frame(8'h15, 2'b00, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0);
      do_frame(8'h15, 2'b00, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0);
      drain();

      // Start glitch shorter than half a bit.
      word_len_i = 2'b11;
      par_en_i   = 1'b0;
      rxd_i = 1'b0;
      wait_ticks(2);
      check("glitch_busy_high", busy_o, 1'b1);
      wait_ticks(3);
      rxd_i = 1'b1;
      wait_ticks(12);
      check("glitch_busy_low", busy_o, 1'b0);
      check("glitch_no_entry", rx_usage_o, 0);

      // Break: line low for three 8N1 frame times.
      word_len_i = 2'b11;
      par_en_i   = 1'b0;
      model_push('{err: 3'b110, data: 8'h00});
      rxd_i = 1'b0;
      wait_ticks(3 * 10 * 16);
      check("break_single_entry", rx_usage_o, 1);
      rxd_i = 1'b1;
      wait_ticks(20);
      check("break_busy_low", busy_o, 1'b0);
      drain();
      do_frame(8'h3C, 2'b11, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
      drain();

      // Holding-register mode: second character is dropped.
      fifo_en_i = 1'b0;
      wait_cycles(3);
      model_flush();
      base_seen = ovr_seen;
      base_exp  = exp_ovr;
      do_frame(8'h11, 2'b11, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
      do_frame(8'h22, 2'b11, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
      check("hold_head", rx_data_o, 8'h11);
      check("hold_usage", rx_usage_o, 1);
      check("hold_overruns", ovr_seen - base_seen, exp_ovr - base_exp);
      check("hold_overrun_once", ovr_seen - base_seen, 1);

      // Full-depth mode: 17 characters, no pops.
      fifo_en_i = 1'b1;
      wait_cycles(3);
      model_flush();
      check("toggle_flush", rx_usage_o, 0);
      base_seen = ovr_seen;
      for (int i = 0; i < 17; i++) begin
         do_frame(8'($urandom), 2'b11, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
      end
      check("full_usage", rx_usage_o, DEPTH);
      check("full_overrun_once", ovr_seen - base_seen, 1);
      drain();

      // Reset mid-DATA discards the partial character and empties the FIFO.
      do_frame(8'h33, 2'b11, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
      check("pre_reset_usage", rx_usage_o, 1);
      rxd_i = 1'b0;
      wait_ticks(16);
      for (int i = 0; i < 3; i++) begin
         rxd_i = 1'(i & 1);
         wait_ticks(16);
      end
      rst_i = 1'b1;
      rxd_i = 1'b1;
      wait_cycles(2);
      rst_i = 1'b0;
      model_flush();
      wait_cycles(2);
      check("midrst_usage", rx_usage_o, 0);
      check("midrst_valid", rx_valid_o, 1'b0);
      check("midrst_busy", busy_o, 1'b0);
      wait_ticks(20);
      do_frame(8'h5A, 2'b11, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
      check("post_rst_usage", rx_usage_o, 1);
      drain();

      // Flush held across the stop-sample push wins.
      do_frame(8'h77, 2'b11, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
      wait_cycles(2);
      check("clr_usage", rx_usage_o, 0);
      check("clr_valid", rx_valid_o, 1'b0);

      // Randomised formats, parity bits and occasional bad stop bits.
      drain_en = 1'b1;
      for (int i = 0; i < 12; i++) begin
         do_frame(8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 7) != 0), 1'b0);
      end
      drain();

      check("overrun_total", ovr_seen, exp_ovr);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
